sram_access_ctrl: RTL and testbench



---
 rtl/sram_ctrl_pkg.sv | 17 +
 rtl/register.sv | 22 ++
 rtl/sram_wait_counter.sv | 27 ++
 rtl/sram_access_ctrl.sv | 116 +++++++++++
 tb/tb_sram_access_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the SRAM access controller
// Contents: access state enum, default wait count, half-word select constants.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEFAULT_WAIT_CYCLES = 5;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/register.sv
// rtl/register.sv - generic load/clear register
// Ports: clk, rst (sync, active-high), ld (load d), clr (sync clear), d, q.
module Register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - 4-bit wait counter timing each 16-bit half-access
// Ports: clk, rst (sync, active-high), clr (to 0), en (increment),
//        cnt (current count), last (cnt == WAIT_CYCLES-1).
module sram_wait_counter
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] cnt,
    output logic       last
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 4'd0;
        end else if (en) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign last = (cnt == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - splits a 32-bit MEM-stage load/store into two timed 16-bit SRAM accesses
// Ports: clk, rst (sync, active-high); MEM_R_EN/MEM_W_EN/Address/Write_Data request side;
//        Read_Data load result; ready (pipeline freeze = ~ready);
//        sram_addr/sram_dq_out/sram_dq_in/sram_dq_oe/sram_we_n SRAM side.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        Address,
    input  logic [31:0]        Write_Data,
    output logic [31:0]        Read_Data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    state_t      state;
    state_t      state_nxt;
    logic        is_write;
    logic        busy;
    logic        half;
    logic        last;
    logic [3:0]  cnt;
    logic        capture_lo;
    logic        capture_hi;
    logic [15:0] rd_lo;
    logic [15:0] rd_hi;

    // Access type is latched on the way out of IDLE so the SRAM strobes depend
    // only on registered state, and a request dropped mid-access still finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            is_write <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                is_write <= MEM_W_EN;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (MEM_R_EN || MEM_W_EN) state_nxt = LOW;
            LOW:     if (last) state_nxt = HIGH;
            HIGH:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == LOW) || (state == HIGH);

    // Counter is held at 0 outside the data phases and wraps to 0 at the end of each half.
    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk (clk),
        .rst (rst),
        .clr (~busy | last),
        .en  (busy),
        .cnt (cnt),
        .last(last)
    );

    always_comb begin
        half        = (state == HIGH) ? HALF_HI : HALF_LO;
        sram_dq_out = 16'h0000;
        case (state)
            LOW:     sram_dq_out = Write_Data[15:0];
            HIGH:    sram_dq_out = Write_Data[31:16];
            default: sram_dq_out = 16'h0000;
        endcase
    end

    assign sram_addr  = {Address[SRAM_AW:2], half};
    assign sram_dq_oe = busy & is_write;
    // we_n releases on the final wait cycle so each half sees a rising edge.
    assign sram_we_n  = ~(busy & is_write & ~last);

    assign capture_lo = (state == LOW)  & last & ~is_write;
    assign capture_hi = (state == HIGH) & last & ~is_write;

    Register #(.WIDTH(16)) u_rd_lo (
        .clk(clk), .rst(rst), .ld(capture_lo), .clr(1'b0), .d(sram_dq_in), .q(rd_lo)
    );

    Register #(.WIDTH(16)) u_rd_hi (
        .clk(clk), .rst(rst), .ld(capture_hi), .clr(1'b0), .d(sram_dq_in), .q(rd_hi)
    );

    assign Read_Data = {rd_hi, rd_lo};
    assign ready     = ~(MEM_R_EN | MEM_W_EN) | (state == DONE);

    logic unused_bits;
    assign unused_bits = ^{Address[31:SRAM_AW+1], Address[1:0], cnt};

    // The requester must not change the request while the pipeline is frozen.
    a_req_stable : assert property (
        @(posedge clk) disable iff (rst)
        (busy && !ready) |-> ($stable(Address) && $stable(Write_Data) &&
                              $stable(MEM_R_EN) && $stable(MEM_W_EN))
    );

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - scoreboard bench for sram_access_ctrl
module tb_sram_access_ctrl;

    localparam int W  = 5;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          MEM_R_EN;
    logic          MEM_W_EN;
    logic [31:0]   Address;
    logic [31:0]   Write_Data;
    logic [31:0]   Read_Data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic [15:0]   sram_dq_in;
    logic          sram_dq_oe;
    logic          sram_we_n;

    logic [15:0]   mem [0:1023];

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   dq;
    } beat_t;

    logic [31:0] txn_q [$];
    beat_t       beat_q [$];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    assign sram_dq_in = mem[sram_addr[9:0]];

    sram_access_ctrl #(
        .WAIT_CYCLES(W),
        .SRAM_AW    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .Address    (Address),
        .Write_Data (Write_Data),
        .Read_Data  (Read_Data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Transaction monitor: completes when ready rises under a live request.
    int          age = 0;
    logic [31:0] exp_rd;
    always @(negedge clk) begin
        if (rst) begin
            age = 0;
        end else if (MEM_R_EN || MEM_W_EN) begin
            if (ready) begin
                if (txn_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_done: got ready=1 expected no completion");
                end else begin
                    exp_rd = txn_q.pop_front();
                    check("done_latency", age, 2 * W + 1);
                    check("read_data_at_done", Read_Data, exp_rd);
                end
                age = 0;
            end else begin
                age++;
            end
        end else begin
            age = 0;
        end
    end

    // Write-beat monitor: counts we_n low cycles, checks each half at its we_n release.
    int    low_cnt = 0;
    beat_t exp_beat;
    always @(negedge clk) begin
        if (rst) begin
            low_cnt = 0;
        end else if (sram_dq_oe && !sram_we_n) begin
            low_cnt++;
        end else if (sram_dq_oe && sram_we_n && low_cnt > 0) begin
            if (beat_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_write_beat: got addr %h expected none", sram_addr);
            end else begin
                exp_beat = beat_q.pop_front();
                check("beat_addr", 32'(sram_addr), 32'(exp_beat.addr));
                check("beat_dq", 32'(sram_dq_out), 32'(exp_beat.dq));
                check("beat_we_low_cycles", low_cnt, W - 1);
            end
            low_cnt = 0;
        end else if (!sram_dq_oe && !sram_we_n) begin
            n_vec++;
            n_miss++;
            $display("FAIL we_without_oe: got we_n=0 oe=0 expected we_n=1");
        end
    end

    task automatic start_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        MEM_R_EN   = r;
        MEM_W_EN   = w;
        Address    = a;
        Write_Data = d;
    endtask

    task automatic end_req();
        @(posedge clk);
        #1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) return;
        end
        n_vec++;
        n_miss++;
        $display("FAIL %s_timeout: got ready=0 after 40 cycles expected ready=1", name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h202] = 16'h5678;
        mem[10'h203] = 16'h1234;
        mem[10'h100] = 16'hAAAA;
        mem[10'h101] = 16'hBBBB;

        rst        = 1'b1;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        Address    = 32'h0;
        Write_Data = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_ready", 32'(ready), 32'h1);
        check("rst_read_data", Read_Data, 32'h0);
        check("rst_we_n", 32'(sram_we_n), 32'h1);
        check("rst_oe", 32'(sram_dq_oe), 32'h0);
        check("rst_addr", 32'(sram_addr), 32'h0);
        check("rst_dq_out", 32'(sram_dq_out), 32'h0);

        // Store
        txn_q.push_back(32'h0000_0000);
        beat_q.push_back('{addr: 18'h00202, dq: 16'hBEEF});
        beat_q.push_back('{addr: 18'h00203, dq: 16'hDEAD});
        start_req(1'b0, 1'b1, 32'h0000_0404, 32'hDEADBEEF);
        wait_ready("store");
        end_req();

        // Load, then hold for 20 idle cycles
        txn_q.push_back(32'h1234_5678);
        start_req(1'b1, 1'b0, 32'h0000_0404, 32'h0);
        wait_ready("load");
        end_req();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("load_hold", Read_Data, 32'h1234_5678);
        end

        // Read and write together: write sequence, Read_Data untouched
        txn_q.push_back(32'h1234_5678);
        beat_q.push_back('{addr: 18'h00400, dq: 16'hF00D});
        beat_q.push_back('{addr: 18'h00401, dq: 16'hCAFE});
        start_req(1'b1, 1'b1, 32'h0000_0800, 32'hCAFEF00D);
        wait_ready("rw");
        end_req();
        @(negedge clk);
        check("rw_read_data", Read_Data, 32'h1234_5678);

        // Reset during the HIGH phase of a load
        start_req(1'b1, 1'b0, 32'h0000_0200, 32'h0);
        repeat (7) @(posedge clk);
        #1;
        rst      = 1'b1;
        MEM_R_EN = 1'b0;
        Address  = 32'h0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_read_data", Read_Data, 32'h0);
        check("midrst_we_n", 32'(sram_we_n), 32'h1);
        check("midrst_oe", 32'(sram_dq_oe), 32'h0);
        check("midrst_addr", 32'(sram_addr), 32'h0);
        check("midrst_ready", 32'(ready), 32'h1);

        // Two loads with the request held throughout
        txn_q.push_back(32'h1234_5678);
        txn_q.push_back(32'h1234_5678);
        start_req(1'b1, 1'b0, 32'h0000_0404, 32'h0);
        wait_ready("b2b_first");
        @(negedge clk);
        check("b2b_gap_ready", 32'(ready), 32'h0);
        wait_ready("b2b_second");
        end_req();
        repeat (3) @(negedge clk);

        check("txn_queue_empty", 32'(txn_q.size()), 32'h0);
        check("beat_queue_empty", 32'(beat_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
